pipeline_memaccess: RTL and testbench

Memory stage of the RV32I five-stage pipeline. It sits between the EX/MEM register and the MEM/WB register. For loads and stores it runs a req/gnt/rvalid transaction on the data-memory bus, aligns and extends load data, and generates store byte-enables. It stalls the upstream pipeline until the access completes and passes a bubble or the completed instruction downstream as M-suffixed signals.

---
 rtl/pipeline_memaccess_pkg.sv | 25 ++
 rtl/pipeline_memaccess_lsu_align.sv | 69 ++++++
 rtl/pipeline_memaccess.sv | 175 +++++++++++++++++
 tb/tb_pipeline_memaccess.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_memaccess_pkg.sv
// Shared configuration for the memory stage: datapath width, funct3 codes, FSM states.
package pipeline_memaccess_pkg;

  localparam int CFG_XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/pipeline_memaccess_lsu_align.sv
// Combinational load/store alignment: byte enables, lane-replicated store data,
// load byte/half extraction with sign/zero extension, and misalignment detect.
// Lane layout assumes a 32-bit word (four byte lanes).
module lsu_align
  import pipeline_memaccess_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o
);

  logic       byte_acc;
  logic       half_acc;
  logic [7:0] rbyte;
  logic [15:0] rhalf;

  // Access size: funct3 100/101 are byte/half only for loads; any unused code is a word
  always_comb begin
    byte_acc = (funct3_i == F3_LB) || (!is_store_i && funct3_i == F3_LBU);
    half_acc = (funct3_i == F3_LH) || (!is_store_i && funct3_i == F3_LHU);
  end

  // Misaligned when the address is not a multiple of the access size
  always_comb begin
    misalign_o = 1'b0;
    if (half_acc)      misalign_o = addr_i[0];
    else if (!byte_acc) misalign_o = |addr_i;
  end

  // Store formatting: replicate the datum across every lane it could land in
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (byte_acc) begin
      be_o    = 4'b0001 << addr_i;
      wdata_o = {(XLEN/8){wdata_i[7:0]}};
    end else if (half_acc) begin
      be_o    = 4'b0011 << {addr_i[1], 1'b0};
      wdata_o = {(XLEN/16){wdata_i[15:0]}};
    end
  end

  // Load formatting: pick the addressed lane, then extend per funct3
  always_comb begin
    case (addr_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   rdata_o = {{(XLEN-8){rbyte[7]}}, rbyte};
      F3_LBU:  rdata_o = {{(XLEN-8){1'b0}}, rbyte};
      F3_LH:   rdata_o = {{(XLEN-16){rhalf[15]}}, rhalf};
      F3_LHU:  rdata_o = {{(XLEN-16){1'b0}}, rhalf};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pipeline_memaccess.sv
// RV32I memory stage: runs req/gnt/rvalid data-bus transactions for loads and
// stores, stalls upstream until the access completes, and presents a bubble or
// the completed instruction to MEM/WB.
module pipeline_memaccess
  import pipeline_memaccess_pkg::*;
#(
  parameter int XLEN           = CFG_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ctrl_reg_wr_enE2M,
  input  logic            i_ctrl_result_srcE2M,
  input  logic            i_ctrl_mem_rd_enM,
  input  logic            i_ctrl_mem_wr_enM,
  input  logic [2:0]      i_funct3M,
  input  logic [XLEN-1:0] i_alu_resultM,
  input  logic [XLEN-1:0] i_write_dataM,
  input  logic [XLEN-1:0] i_PCPlus4M,
  input  logic [XLEN-1:0] i_PCTargetM,
  input  logic [4:0]      i_regfile_rd_addrM,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_ctrl_reg_wr_enM,
  output logic            o_ctrl_result_srcM,
  output logic [XLEN-1:0] o_alu_resultM,
  output logic [XLEN-1:0] o_mem_readdataM,
  output logic [XLEN-1:0] o_PCPlus4M,
  output logic [XLEN-1:0] o_PCTargetM,
  output logic [4:0]      o_regfile_rd_addrM,
  output logic            o_stall,
  output logic            o_misalign,
  output logic            o_bus_err
);

  mem_state_e      state_q;
  logic [7:0]      cnt_q;
  logic [XLEN-1:0] load_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic            err_q;

  logic            is_mem, is_store, mis, go, tmo;
  logic [7:0]      cnt_inc;
  logic [XLEN-1:0] addr_w;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            al_mis;

  // Both enables high is treated as a store
  assign is_mem   = i_ctrl_mem_rd_enM | i_ctrl_mem_wr_enM;
  assign is_store = i_ctrl_mem_wr_enM;
  assign mis      = is_mem & al_mis;
  assign go       = is_mem & ~mis;
  assign addr_w   = {i_alu_resultM[XLEN-1:2], 2'b00};
  assign cnt_inc  = cnt_q + 8'd1;
  // Compare with >= so a grant landing exactly on the limit still times out in DATA
  assign tmo      = cnt_inc >= 8'(TIMEOUT_CYCLES);

  // Load data is formatted from the captured word; the held instruction's
  // funct3/address are still on the inputs because EX/MEM is frozen
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (i_funct3M),
    .addr_i     (i_alu_resultM[1:0]),
    .is_store_i (is_store),
    .wdata_i    (i_write_dataM),
    .rdata_i    (load_q),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_mis)
  );

  // Transaction FSM with timeout counter, held request and load capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (go) begin
            addr_q  <= addr_w;
            wdata_q <= al_wdata;
            be_q    <= is_store ? al_be : 4'b0000;
            we_q    <= is_store;
            if (i_dmem_gnt) state_q <= is_store ? ST_DONE : ST_DATA;
            else            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt_q <= cnt_inc;
          if (i_dmem_gnt) state_q <= we_q ? ST_DONE : ST_DATA;
          else if (tmo) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
          end
        end
        ST_DATA: begin
          cnt_q <= cnt_inc;
          if (i_dmem_rvalid) begin
            load_q  <= i_dmem_rdata;
            state_q <= ST_DONE;
          end else if (tmo) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus drive: live request from the inputs in IDLE, held request in ADDR
  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_be    = 4'b0000;
    o_dmem_addr  = addr_q;
    o_dmem_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        o_dmem_req   = go;
        o_dmem_we    = go & is_store;
        o_dmem_be    = (go & is_store) ? al_be : 4'b0000;
        o_dmem_addr  = addr_w;
        o_dmem_wdata = al_wdata;
      end
      ST_ADDR: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = we_q;
        o_dmem_be  = be_q;
      end
      default: ;
    endcase
    // Reset drops the request at once, even while EX/MEM still shows a memory op
    if (i_rst) begin
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_dmem_be  = 4'b0000;
    end
  end

  // Stall, bubble insertion and error flags
  always_comb begin
    o_stall           = go & (state_q != ST_DONE);
    o_misalign        = mis & (state_q == ST_IDLE);
    o_bus_err         = (state_q == ST_DONE) & err_q;
    o_ctrl_reg_wr_enM = i_ctrl_reg_wr_enE2M & ~o_stall & ~mis & ~o_bus_err;
  end

  assign o_ctrl_result_srcM = i_ctrl_result_srcE2M;
  assign o_alu_resultM      = i_alu_resultM;
  assign o_mem_readdataM    = al_rdata;
  assign o_PCPlus4M         = i_PCPlus4M;
  assign o_PCTargetM        = i_PCTargetM;
  assign o_regfile_rd_addrM = i_regfile_rd_addrM;

endmodule

// File: tb/tb_pipeline_memaccess.sv
// Randomized self-checking bench for pipeline_memaccess against an
// event-timing reference model.
module tb_pipeline_memaccess;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_ctrl_reg_wr_enE2M, i_ctrl_result_srcE2M;
  logic            i_ctrl_mem_rd_enM, i_ctrl_mem_wr_enM;
  logic [2:0]      i_funct3M;
  logic [XLEN-1:0] i_alu_resultM, i_write_dataM, i_PCPlus4M, i_PCTargetM;
  logic [4:0]      i_regfile_rd_addrM;
  logic            o_dmem_req, o_dmem_we;
  logic [XLEN-1:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]      o_dmem_be;
  logic            i_dmem_gnt, i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;
  logic            o_ctrl_reg_wr_enM, o_ctrl_result_srcM;
  logic [XLEN-1:0] o_alu_resultM, o_mem_readdataM, o_PCPlus4M, o_PCTargetM;
  logic [4:0]      o_regfile_rd_addrM;
  logic            o_stall, o_misalign, o_bus_err;

  always #5 i_clk = ~i_clk;

  pipeline_memaccess #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ctrl_reg_wr_enE2M(i_ctrl_reg_wr_enE2M), .i_ctrl_result_srcE2M(i_ctrl_result_srcE2M),
    .i_ctrl_mem_rd_enM(i_ctrl_mem_rd_enM), .i_ctrl_mem_wr_enM(i_ctrl_mem_wr_enM),
    .i_funct3M(i_funct3M), .i_alu_resultM(i_alu_resultM), .i_write_dataM(i_write_dataM),
    .i_PCPlus4M(i_PCPlus4M), .i_PCTargetM(i_PCTargetM), .i_regfile_rd_addrM(i_regfile_rd_addrM),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_ctrl_reg_wr_enM(o_ctrl_reg_wr_enM), .o_ctrl_result_srcM(o_ctrl_result_srcM),
    .o_alu_resultM(o_alu_resultM), .o_mem_readdataM(o_mem_readdataM),
    .o_PCPlus4M(o_PCPlus4M), .o_PCTargetM(o_PCTargetM), .o_regfile_rd_addrM(o_regfile_rd_addrM),
    .o_stall(o_stall), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---- reference model ----
  function automatic int acc_size(input bit st, input logic [2:0] f3);
    if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input bit st, input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % acc_size(st, f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(1'b1, f3);
    if (sz == 1) return 4'(1 << a[1:0]);
    if (sz == 2) return 4'(3 << a[1:0]);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    int sz = acc_size(1'b1, f3);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return w;
    endcase
  endfunction

  // Cycle (from 0 = first presented) in which DONE shows, and whether it is a timeout.
  // ADDR/DATA cycles are 1,2,...; gnt at cycle g, rvalid at cycle g+r.
  task automatic m_timing(input bit st, input int g, input int r, output int done, output bit err);
    int first_to;
    if (g > TMO) begin done = TMO + 1; err = 1'b1; return; end
    if (st) begin done = g + 1; err = 1'b0; return; end
    first_to = (TMO > g + 1) ? TMO : g + 1;
    if (g + r <= first_to) begin done = g + r + 1; err = 1'b0; end
    else begin done = first_to + 1; err = 1'b1; end
  endtask

  task automatic idle_inputs();
    i_ctrl_mem_rd_enM = 1'b0; i_ctrl_mem_wr_enM = 1'b0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
  endtask

  task automatic drive_common(input bit rw, input logic [31:0] a);
    i_ctrl_reg_wr_enE2M  = rw;
    i_ctrl_result_srcE2M = rbit();
    i_alu_resultM        = a;
    i_PCPlus4M           = $urandom;
    i_PCTargetM          = $urandom;
    i_regfile_rd_addrM   = 5'($urandom);
  endtask

  task automatic run_nonmem(input logic [31:0] a, input bit rw);
    drive_common(rw, a);
    idle_inputs();
    i_dmem_gnt = rbit(); i_dmem_rvalid = rbit();
    @(negedge i_clk);
    chk("nm_stall", 32'(o_stall), 32'd0);
    chk("nm_req", 32'(o_dmem_req), 32'd0);
    chk("nm_alu", o_alu_resultM, a);
    chk("nm_regwr", 32'(o_ctrl_reg_wr_enM), 32'(rw));
    chk("nm_pc4", o_PCPlus4M, i_PCPlus4M);
    chk("nm_rd", 32'(o_regfile_rd_addrM), 32'(i_regfile_rd_addrM));
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdv, input int g, input int r,
                        input bit rw);
    bit st, mis, err;
    int done, lim;
    st = wr;
    drive_common(rw, a);
    i_ctrl_mem_rd_enM = rd; i_ctrl_mem_wr_enM = wr;
    i_funct3M = f3; i_write_dataM = wd; i_dmem_rdata = rdv;
    mis = m_mis(st, f3, a);
    if (mis) begin
      i_dmem_gnt = rbit(); i_dmem_rvalid = 1'b0;
      @(negedge i_clk);
      chk("mis_flag", 32'(o_misalign), 32'd1);
      chk("mis_req", 32'(o_dmem_req), 32'd0);
      chk("mis_stall", 32'(o_stall), 32'd0);
      chk("mis_regwr", 32'(o_ctrl_reg_wr_enM), 32'd0);
      @(posedge i_clk); #1;
      idle_inputs();
      return;
    end
    m_timing(st, g, r, done, err);
    lim = (g < TMO) ? g : TMO;
    for (int c = 0; c <= done; c++) begin
      i_dmem_gnt    = (c == g) || (c > g && rbit());
      i_dmem_rvalid = st ? rbit() : ((c == g + r) || (c <= g && rbit()));
      @(negedge i_clk);
      chk("req", 32'(o_dmem_req), 32'(c <= lim));
      chk("stall", 32'(o_stall), 32'(c != done));
      chk("misalign", 32'(o_misalign), 32'd0);
      if (c <= lim) begin
        chk("addr", o_dmem_addr, {a[31:2], 2'b00});
        chk("we", 32'(o_dmem_we), 32'(st));
        if (st) begin
          chk("be", 32'(o_dmem_be), 32'(m_be(f3, a)));
          chk("wdata", o_dmem_wdata, m_wd(f3, wd));
        end
      end
      if (c != done) begin
        chk("bubble", 32'(o_ctrl_reg_wr_enM), 32'd0);
        @(posedge i_clk); #1;
      end else begin
        chk("bus_err", 32'(o_bus_err), 32'(err));
        chk("done_regwr", 32'(o_ctrl_reg_wr_enM), 32'(rw && !err));
        chk("done_alu", o_alu_resultM, a);
        chk("done_pct", o_PCTargetM, i_PCTargetM);
        if (!st && !err) chk("rdata", o_mem_readdataM, m_load(f3, a, rdv));
      end
    end
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    drive_common(1'b0, 32'h0);
    i_funct3M = 3'b010; i_write_dataM = '0; i_dmem_rdata = '0;
    idle_inputs();
    #12;
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_be", 32'(o_dmem_be), 32'd0);
    chk("rst_mis", 32'(o_misalign), 32'd0);
    chk("rst_berr", 32'(o_bus_err), 32'd0);
    chk("rst_rdata", o_mem_readdataM, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    run_nonmem(32'h0000_1234, 1'b1);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0, 1, 1'b1); // LB
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 32'h0, 3, 1, 1'b0); // SH
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 1, 1'b1);         // LW misaligned
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1111_2222, 0, 100, 1'b1); // timeout
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0800, 32'h5555_AAAA, 32'h0, 1, 1, 1'b0); // both -> store
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0900, 32'h0, 32'h0, 6, 1, 1'b0);         // store timeout

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) run_nonmem($urandom, rbit());
      else run_op(kind != 2, kind != 1, 3'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(1, 3), rbit());
    end

    // Reset in DATA, then a late rvalid
    drive_common(1'b1, 32'h0000_0040);
    i_ctrl_mem_rd_enM = 1'b1; i_ctrl_mem_wr_enM = 1'b0; i_funct3M = 3'b010;
    i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b0;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(o_dmem_req), 32'd0);
    idle_inputs();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    chk("late_rv_req", 32'(o_dmem_req), 32'd0);
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    @(negedge i_clk);
    chk("late_rv_rdata", o_mem_readdataM, 32'd0);
    chk("late_rv_stall", 32'(o_stall), 32'd0);
    @(posedge i_clk); #1;
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0052, 32'h0, 32'hC001_7FFF, 1, 2, 1'b1); // LHU after reset

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
